// File: rtl/mem_resp_types.sv
// mem_resp_types: shared FSM state, request record and helpers for mem_responder
package mem_resp_types;
   typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_port_state_t;
   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  rmask;
      logic [3:0]  wmask;
      logic [31:0] wdata;
   } mem_req_t;
   function automatic int mem_idx_w(input int words);
      return $clog2(words);
   endfunction
   function automatic logic [31:0] mask_bytes(input logic [31:0] word, input logic [3:0] m);
      return word & {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
   endfunction
   // Full word off a word boundary, or halfword off a halfword boundary
   function automatic logic misaligned(input mem_req_t r);
      logic [3:0] m;
      m = r.rmask | r.wmask;
      return (m == 4'hF && r.addr[1:0] != 2'b00) || ((m == 4'h3 || m == 4'hC) && r.addr[0]);
   endfunction
endpackage

// File: rtl/mem_port_fsm.sv
// mem_port_fsm: per-port IDLE/BUSY/RESP sequencer with latency counter and request latch
//   req     : live request from the CPU side
//   cur     : request being serviced (live request while IDLE, so LATENCY==1 works)
//   capture : request accepted this cycle
//   go_resp : next edge enters RESP (read latch / write strobe)
//   in_resp : response cycle
module mem_port_fsm
   import mem_resp_types::*;
#(
   parameter int LATENCY = 2
) (
   input  logic     clk,
   input  logic     rst,
   input  mem_req_t req,
   output mem_req_t cur,
   output logic     capture,
   output logic     go_resp,
   output logic     in_resp
);
   localparam int CW = LATENCY > 2 ? $clog2(LATENCY - 1) : 1;
   localparam logic [CW-1:0] CNT_INIT = LATENCY > 2 ? CW'(LATENCY - 2) : '0;
   mem_port_state_t state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   mem_req_t lat;
   logic req_v;
   assign req_v = |(req.rmask | req.wmask);
   always_comb begin
      state_nxt = state;
      cnt_nxt = cnt;
      case (state)
         IDLE: if (req_v) begin
            state_nxt = LATENCY == 1 ? RESP : BUSY;
            cnt_nxt = CNT_INIT;
         end
         BUSY: begin
            state_nxt = cnt == '0 ? RESP : BUSY;
            cnt_nxt = cnt == '0 ? cnt : cnt - CW'(1);
         end
         default: state_nxt = IDLE;
      endcase
   end
   assign capture = state == IDLE && req_v;
   // Gated by rst so an aborted transaction never latches read data or writes
   assign go_resp = !rst && state != RESP && state_nxt == RESP;
   assign in_resp = state == RESP;
   assign cur = state == IDLE ? req : lat;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         lat <= '0;
      end else begin
         state <= state_nxt;
         cnt <= cnt_nxt;
         if (capture) lat <= req;
      end
   end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: dual-port fixed-latency memory responder for the cpu imem/dmem ports
module mem_responder
  import mem_resp_types::*;
#(
  parameter int    LATENCY       = 2,
  parameter int    MEM_WORDS     = 4096,
  parameter string MEM_INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp
`ifdef MEMRESP_ALIGN_CHECK_EN
  ,
  output logic        mem_err
`endif
);
  localparam int MEM_IDX_W = mem_idx_w(MEM_WORDS);
  logic [31:0] mem [MEM_WORDS];
  initial for (int i = 0; i < MEM_WORDS; i++) mem[i] = '0;
  mem_req_t ireq, dreq, icur, dcur;
  logic i_cap, d_cap, i_go, d_go;
  logic [31:0] i_q, d_q;
  logic [MEM_IDX_W-1:0] iidx, didx;
  assign ireq = '{addr: imem_addr, rmask: imem_rmask, wmask: 4'h0, wdata: 32'h0};
  assign dreq = '{addr: dmem_addr, rmask: dmem_rmask, wmask: dmem_wmask, wdata: dmem_wdata};
  mem_port_fsm #(.LATENCY(LATENCY)) u_ifsm (
    .clk(clk), .rst(rst), .req(ireq), .cur(icur),
    .capture(i_cap), .go_resp(i_go), .in_resp(imem_resp)
  );
  mem_port_fsm #(.LATENCY(LATENCY)) u_dfsm (
    .clk(clk), .rst(rst), .req(dreq), .cur(dcur),
    .capture(d_cap), .go_resp(d_go), .in_resp(dmem_resp)
  );
  assign iidx = icur.addr[MEM_IDX_W+1:2];
  assign didx = dcur.addr[MEM_IDX_W+1:2];
  always_ff @(posedge clk) begin
    if (d_go) for (int b = 0; b < 4; b++) if (dcur.wmask[b]) mem[didx][8*b +: 8] <= dcur.wdata[8*b +: 8];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      i_q <= '0;
      d_q <= '0;
    end else begin
      if (i_go) i_q <= mask_bytes(mem[iidx], icur.rmask);
      if (d_go) d_q <= mask_bytes(mem[didx], dcur.rmask);
    end
  end
  assign imem_rdata = imem_resp ? i_q : '0;
  assign dmem_rdata = dmem_resp ? d_q : '0;
`ifdef MEMRESP_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) mem_err <= 1'b0;
    else if ((i_cap && misaligned(ireq)) || (d_cap && misaligned(dreq))) mem_err <= 1'b1;
  end
`endif
  logic unused_ok;
  assign unused_ok = &{1'b0, i_cap, d_cap, icur.addr[31:MEM_IDX_W+2], icur.addr[1:0], icur.wmask,
                       icur.wdata, dcur.addr[31:MEM_IDX_W+2], dcur.addr[1:0]};
endmodule
